// File: rtl/sweep_sched.sv
// Frequency sweep scheduler.
// Steps a DDS frequency code from FREQ_START to FREQ_END and, at each point,
// waits for the analog path to settle. It then enables the FFT core and waits
// for one accepted frame (after discarding DISCARD_FRM frames) before moving on.
// A watchdog aborts a point that never delivers its accepting frame.
// All outputs come straight from flops.
module sweep_sched #(
  parameter logic [15:0] FREQ_START  = 16'd1,
  parameter logic [15:0] FREQ_STEP   = 16'd1,
  parameter logic [15:0] FREQ_END    = 16'd150,
  parameter logic [15:0] SETTLE_CYC  = 16'd50000,
  parameter logic [3:0]  DISCARD_FRM = 4'd1,
  parameter logic [23:0] TIMEOUT_CYC = 24'd10000000
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        frame_done,
  output logic [15:0] freq,
  output logic        next_freq,
  output logic        learn_en,
  output logic        fft_valid,
  output logic [7:0]  point_idx,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_CAPTURE = 3'd2,
    S_STEP    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] freq_q, freq_d;
  logic [7:0]  point_idx_q, point_idx_d;
  logic        next_freq_q, next_freq_d;
  logic        learn_en_q, learn_en_d;
  logic        fft_valid_q, fft_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        timeout_err_q, timeout_err_d;
  logic [15:0] settle_cnt_q, settle_cnt_d;
  logic [3:0]  frame_cnt_q, frame_cnt_d;
  logic [23:0] tmo_cnt_q, tmo_cnt_d;

  // Next frequency is formed one bit wider so a step past 16'hFFFF is seen
  // as "beyond the end" instead of wrapping to a small code.
  logic [16:0] freq_sum;
  logic        settle_last;
  logic        tmo_last;
  logic        frame_accept;

  assign freq_sum     = {1'b0, freq_q} + {1'b0, FREQ_STEP};
  // A zero settle or timeout length behaves like a length of one cycle.
  assign settle_last  = ({1'b0, settle_cnt_q} + 17'd1) >= {1'b0, SETTLE_CYC};
  assign tmo_last     = ({1'b0, tmo_cnt_q} + 25'd1) >= {1'b0, TIMEOUT_CYC};
  // The (DISCARD_FRM+1)-th frame of a point is the one that is kept.
  assign frame_accept = frame_done && (frame_cnt_q == DISCARD_FRM);

  // State and output registers, asynchronously cleared by rst_n.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      freq_q        <= 16'd0;
      point_idx_q   <= 8'd0;
      next_freq_q   <= 1'b0;
      learn_en_q    <= 1'b0;
      fft_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      settle_cnt_q  <= 16'd0;
      frame_cnt_q   <= 4'd0;
      tmo_cnt_q     <= 24'd0;
    end else begin
      state_q       <= state_d;
      freq_q        <= freq_d;
      point_idx_q   <= point_idx_d;
      next_freq_q   <= next_freq_d;
      learn_en_q    <= learn_en_d;
      fft_valid_q   <= fft_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      settle_cnt_q  <= settle_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  // Next-state and next-output logic; abort overrides everything, including start.
  always_comb begin
    state_d       = state_q;
    freq_d        = freq_q;
    point_idx_d   = point_idx_q;
    next_freq_d   = 1'b0;
    learn_en_d    = learn_en_q;
    fft_valid_d   = fft_valid_q;
    busy_d        = busy_q;
    done_d        = done_q;
    timeout_err_d = timeout_err_q;
    settle_cnt_d  = settle_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;

    if (abort) begin
      // Cancel keeps freq, point_idx and timeout_err for post-mortem reading.
      state_d      = S_IDLE;
      learn_en_d   = 1'b0;
      fft_valid_d  = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      settle_cnt_d = 16'd0;
      frame_cnt_d  = 4'd0;
      tmo_cnt_d    = 24'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // busy is low only in these two states, so start is honoured only here.
          if (start) begin
            state_d       = S_SETTLE;
            freq_d        = FREQ_START;
            point_idx_d   = 8'd0;
            next_freq_d   = 1'b1;
            learn_en_d    = 1'b1;
            fft_valid_d   = 1'b0;
            busy_d        = 1'b1;
            done_d        = 1'b0;
            timeout_err_d = 1'b0;
            settle_cnt_d  = 16'd0;
            frame_cnt_d   = 4'd0;
            tmo_cnt_d     = 24'd0;
          end
        end

        S_SETTLE: begin
          fft_valid_d = 1'b0;
          if (settle_last) begin
            state_d      = S_CAPTURE;
            fft_valid_d  = 1'b1;
            settle_cnt_d = 16'd0;
            frame_cnt_d  = 4'd0;
            tmo_cnt_d    = 24'd0;
          end else begin
            settle_cnt_d = settle_cnt_q + 16'd1;
          end
        end

        S_CAPTURE: begin
          // An accepting frame on the final watchdog cycle still counts.
          if (frame_accept) begin
            state_d     = S_STEP;
            fft_valid_d = 1'b0;
            frame_cnt_d = 4'd0;
            tmo_cnt_d   = 24'd0;
          end else if (tmo_last) begin
            state_d       = S_IDLE;
            timeout_err_d = 1'b1;
            fft_valid_d   = 1'b0;
            learn_en_d    = 1'b0;
            busy_d        = 1'b0;
            frame_cnt_d   = 4'd0;
            tmo_cnt_d     = 24'd0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 24'd1;
            if (frame_done) begin
              frame_cnt_d = frame_cnt_q + 4'd1;
            end
          end
        end

        S_STEP: begin
          fft_valid_d = 1'b0;
          if (freq_sum > {1'b0, FREQ_END}) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            learn_en_d = 1'b0;
          end else begin
            state_d      = S_SETTLE;
            freq_d       = freq_sum[15:0];
            // The index only labels points; it saturates and never ends the sweep.
            point_idx_d  = (point_idx_q == 8'hFF) ? point_idx_q : point_idx_q + 8'd1;
            next_freq_d  = 1'b1;
            settle_cnt_d = 16'd0;
          end
        end

        default: begin
          state_d     = S_IDLE;
          learn_en_d  = 1'b0;
          fft_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b0;
        end
      endcase
    end
  end

  assign freq        = freq_q;
  assign point_idx   = point_idx_q;
  assign next_freq   = next_freq_q;
  assign learn_en    = learn_en_q;
  assign fft_valid   = fft_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/sweep_sched.md
SWEEP_SCHED -- requirements
Module: sweep_sched

Interface
REQ-001 SHALL have parameter FREQ_START, default 16'd1, first sweep frequency code (units of 200 Hz).
REQ-002 SHALL have parameter FREQ_STEP, default 16'd1, frequency code increment per point.
REQ-003 SHALL have parameter FREQ_END, default 16'd150, last allowed frequency code, inclusive.
REQ-004 SHALL have parameter SETTLE_CYC, default 16'd50000, clk_50m cycles to wait after each frequency change.
REQ-005 SHALL have parameter DISCARD_FRM, default 4'd1, FFT frames discarded per point before the accepted frame.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 24'd10000000, maximum cycles in WAIT_FRAME.
REQ-007 SHALL have port clk_50m, input, 1, sole clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1, single-cycle sweep request (debounced key pulse).
REQ-010 SHALL have port abort, input, 1, single-cycle cancel request.
REQ-011 SHALL have port frame_done, input, 1, single-cycle pulse marking one complete FFT frame stored, already in clk_50m domain.
REQ-012 SHALL have port freq, output, 16, current DDS frequency code.
REQ-013 SHALL have port next_freq, output, 1, one-cycle pulse when freq changes.
REQ-014 SHALL have port learn_en, output, 1, DDS stimulus enable.
REQ-015 SHALL have port fft_valid, output, 1, FFT core run enable (ANDed into its aresetn).
REQ-016 SHALL have port point_idx, output, 8, index of current sweep point, 0-based.
REQ-017 SHALL have port busy, output, 1; done, output, 1; timeout_err, output, 1.

Function
REQ-018 SHALL implement states IDLE, SETTLE, CAPTURE, STEP, DONE.
REQ-019 IDLE: on start SHALL load freq=FREQ_START, point_idx=0, set learn_en=1, busy=1, clear done and timeout_err, pulse next_freq, enter SETTLE next cycle.
REQ-020 SETTLE: SHALL count SETTLE_CYC cycles with fft_valid=0, then enter CAPTURE with fft_valid=1 and frame counter cleared.
REQ-021 CAPTURE: each frame_done SHALL increment frame counter; the (DISCARD_FRM+1)-th frame_done SHALL enter STEP next cycle.
REQ-022 CAPTURE: if TIMEOUT_CYC cycles elapse without the accepting frame_done, SHALL set timeout_err=1 (sticky), clear fft_valid, learn_en, busy, and return to IDLE.
REQ-023 STEP: SHALL drive fft_valid=0; compute freq+FREQ_STEP at 17 bits; if sum > FREQ_END enter DONE, else load sum into freq, increment point_idx, pulse next_freq, enter SETTLE.
REQ-024 DONE: SHALL hold done=1, busy=0, learn_en=0, fft_valid=0, freq and point_idx frozen; start SHALL restart per REQ-019.
REQ-025 frame_done outside CAPTURE SHALL be ignored; start while busy=1 SHALL be ignored.
REQ-026 abort in any state SHALL return to IDLE next cycle with learn_en=0, fft_valid=0, busy=0, done=0; freq, point_idx, timeout_err held.
REQ-027 start and abort in same cycle SHALL be treated as abort only.
REQ-028 next_freq SHALL be exactly one cycle wide and coincide with the cycle freq takes its new value.
REQ-029 point_idx SHALL saturate at 255; sweep termination depends only on freq.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, freq=0, point_idx=0, all 1-bit outputs 0, all counters 0.
REQ-032 Reset asserted mid-sweep SHALL abandon the sweep with no further next_freq pulses after release until a new start.

Verification (FREQ_START=10, FREQ_STEP=5, FREQ_END=20, SETTLE_CYC=4, DISCARD_FRM=1, TIMEOUT_CYC=100)
REQ-033 Full sweep: start, then two frame_done per point -> freq 10,15,20, three next_freq pulses, point_idx 0..2, done=1, busy=0.
REQ-034 Settle gating: frame_done pulses during SETTLE -> ignored; fft_valid rises exactly 4 cycles after entering SETTLE.
REQ-035 Timeout: start, no frame_done -> after 100 CAPTURE cycles timeout_err=1, busy=0, fft_valid=0, state IDLE, freq=10.
REQ-036 Abort: abort during CAPTURE at freq=15 -> next cycle busy=0, fft_valid=0, learn_en=0, freq stays 15; simultaneous start+abort in IDLE -> no sweep begins.
REQ-037 Reset mid-sweep: rst_n low at freq=15 -> freq=0, all flags 0 immediately; after release no activity until start.
REQ-038 Overflow: FREQ_START=16'hFFFE, FREQ_STEP=5, FREQ_END=16'hFFFF -> single point then DONE, no wrap to small freq.
